apb_slave_regfile: RTL and testbench

APB3 completer (responder) for the AHB-to-APB bridge's APB side. It provides a 16-entry × 32-bit register file with a programmable number of wait states and PSLVERR on illegal accesses. It is the bench's reference APB target behind the bridge, and can also be instantiated standalone as the peripheral model for APB-only tests.

---
 rtl/apb_slave_regfile_pkg.sv | 13 +
 rtl/apb_slave_regfile_if.sv | 25 ++
 rtl/apb_slave_regfile_addr_decode.sv | 26 ++
 rtl/apb_slave_regfile.sv | 131 +++++++++++++
 tb/tb_apb_slave_regfile.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_slave_regfile_pkg.sv
// Shared types and constants for the APB register-file completer.
package apb_slave_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  localparam int         NUM_REGS     = 16;
  localparam logic [3:0] REG_WAIT_CFG = 4'd14;
  localparam logic [3:0] REG_ID       = 4'd15;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB3 bus bundle between a requester (master) and the register-file completer (slave).
interface apb_slave_regfile_if #(
  parameter int ADDR_W = 12
);

  logic              Psel;
  logic              Penable;
  logic              Pwrite;
  logic [ADDR_W-1:0] Paddr;
  logic [31:0]       Pwdata;
  logic [31:0]       Prdata;
  logic              Pready;
  logic              Pslverr;

  modport master (
    output Psel, Penable, Pwrite, Paddr, Pwdata,
    input  Prdata, Pready, Pslverr
  );

  modport slave (
    input  Psel, Penable, Pwrite, Paddr, Pwdata,
    output Prdata, Pready, Pslverr
  );

endinterface

// File: rtl/apb_slave_regfile_addr_decode.sv
// Combinational address decode: register index plus the illegal-access flag.
module apb_slave_addr_decode
  import apb_slave_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              write,
  output logic [3:0]        idx,
  output logic              err
);

  logic misaligned;
  logic out_of_range;
  logic ro_write;

  // Anything beyond byte offset 0x3C, any sub-word offset, or a write to ID is refused.
  always_comb begin
    idx          = addr[5:2];
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = ((addr >> 6) != '0);
    ro_write     = write && (addr[5:2] == REG_ID);
    err          = misaligned || out_of_range || ro_write;
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer: 14 RW registers, a wait-state config register and a read-only ID,
// with a programmable number of wait states and PSLVERR on illegal accesses.
module apb_slave_regfile
  import apb_slave_pkg::*;
#(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] ID_VALUE = 32'hA5B0_0001,
  parameter logic [3:0]  WAIT_RST = 4'd0
) (
  input  logic              Pclk,
  input  logic              Preset,
  apb_slave_regfile_if.slave bus
);

  localparam int NUM_GP = NUM_REGS - 2;

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;
  logic        capture;
  logic        complete;
  logic        commit;

  logic        cap_write;
  logic        cap_err;
  logic [3:0]  cap_idx;

  logic [3:0]  dec_idx;
  logic        dec_err;

  logic [31:0] regs [0:NUM_GP-1];
  logic [3:0]  wait_cfg;
  logic [31:0] rd_val;

  apb_slave_addr_decode #(
    .ADDR_W(ADDR_W)
  ) u_decode (
    .addr (bus.Paddr),
    .write(bus.Pwrite),
    .idx  (dec_idx),
    .err  (dec_err)
  );

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // A SETUP seen while already in ACCESS restarts the transfer with the new request.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Psel && !bus.Penable) begin
          state_next = ACCESS;
          cnt_next   = wait_cfg;
          capture    = 1'b1;
        end
      end
      ACCESS: begin
        if (!bus.Psel) begin
          state_next = IDLE;
        end else if (!bus.Penable) begin
          cnt_next = wait_cfg;
          capture  = 1'b1;
        end else if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      cap_write <= 1'b0;
      cap_err   <= 1'b0;
      cap_idx   <= '0;
    end else if (capture) begin
      cap_write <= bus.Pwrite;
      cap_err   <= dec_err;
      cap_idx   <= dec_idx;
    end
  end

  assign commit = complete && cap_write && !cap_err;

  // Pwdata is taken on the completing edge; a new WAIT_CFG only applies to later transfers.
  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      for (int i = 0; i < NUM_GP; i++) begin
        regs[i] <= '0;
      end
      wait_cfg <= WAIT_RST;
    end else if (commit) begin
      if (cap_idx == REG_WAIT_CFG) begin
        wait_cfg <= bus.Pwdata[3:0];
      end else if (cap_idx < REG_WAIT_CFG) begin
        regs[cap_idx] <= bus.Pwdata;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (cap_idx == REG_ID) begin
      rd_val = ID_VALUE;
    end else if (cap_idx == REG_WAIT_CFG) begin
      rd_val = {28'd0, wait_cfg};
    end else begin
      rd_val = regs[cap_idx];
    end
  end

  assign bus.Pready  = complete;
  assign bus.Pslverr = complete && cap_err;
  assign bus.Prdata  = (complete && !cap_err) ? rd_val : 32'd0;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench for apb_slave_regfile against an array-based register model.
module tb_apb_slave_regfile;

  localparam int          ADDR_W   = 12;
  localparam logic [31:0] ID_VALUE = 32'hA5B0_0001;
  localparam logic [3:0]  WAIT_RST = 4'd2;
  localparam int          MAX_WAIT = 40;

  logic Pclk = 1'b0;
  logic Preset;

  always #5 Pclk = ~Pclk;

  apb_slave_regfile_if #(.ADDR_W(ADDR_W)) bus ();

  apb_slave_regfile #(
    .ADDR_W  (ADDR_W),
    .ID_VALUE(ID_VALUE),
    .WAIT_RST(WAIT_RST)
  ) dut (
    .Pclk  (Pclk),
    .Preset(Preset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] model_regs [16];
  logic [3:0]  model_wait;

  function automatic bit model_err(input bit wr, input logic [ADDR_W-1:0] a);
    int ai;
    ai = int'(a);
    return (ai % 4 != 0) || (ai >= 64) || (wr && ((ai / 4) % 16 == 15));
  endfunction

  function automatic logic [31:0] model_read(input bit wr, input logic [ADDR_W-1:0] a);
    int idx;
    idx = (int'(a) / 4) % 16;
    if (model_err(wr, a)) return 32'd0;
    if (idx == 15) return ID_VALUE;
    if (idx == 14) return {28'd0, model_wait};
    return model_regs[idx];
  endfunction

  task automatic model_write(input bit wr, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    int idx;
    idx = (int'(a) / 4) % 16;
    if (wr && !model_err(wr, a)) begin
      if (idx == 14) model_wait = d[3:0];
      else if (idx < 14) model_regs[idx] = d;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_regs[i] = 32'd0;
    model_wait = WAIT_RST;
  endtask

  task automatic idle_bus();
    bus.Psel    = 1'b0;
    bus.Penable = 1'b0;
    bus.Pwrite  = 1'b0;
    bus.Paddr   = '0;
    bus.Pwdata  = 32'd0;
  endtask

  // Starts at 1 time unit after a rising edge and returns at the same phase,
  // so consecutive calls produce back-to-back transfers with no idle cycle.
  task automatic apb_xfer(input bit wr, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output logic slverr,
                          output int waits, output bit ok);
    bus.Psel    = 1'b1;
    bus.Penable = 1'b0;
    bus.Pwrite  = wr;
    bus.Paddr   = a;
    bus.Pwdata  = d;
    @(posedge Pclk); #1;
    bus.Penable = 1'b1;
    #1;
    waits = 0;
    ok    = 1'b0;
    while (waits < MAX_WAIT) begin
      if (bus.Pready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge Pclk); #2;
      waits++;
    end
    rdata  = bus.Prdata;
    slverr = bus.Pslverr;
    if (ok) begin
      @(posedge Pclk); #1;
    end
    idle_bus();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        se;
    int          w;
    bit          ok;
    logic [ADDR_W-1:0] addrs [2];
    addrs[0] = 12'h038;
    addrs[1] = 12'h03C;
    Preset = 1'b1;
    idle_bus();
    model_reset();
    @(posedge Pclk); @(posedge Pclk); #1;
    checks++;
    if (bus.Pready !== 1'b0 || bus.Pslverr !== 1'b0 || bus.Prdata !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got ready=%b err=%b rdata=%h, want 0/0/0",
               bus.Pready, bus.Pslverr, bus.Prdata);
    end
    Preset = 1'b0;
    @(posedge Pclk); #1;
    checks++;
    if (bus.Pready !== 1'b0 || bus.Pslverr !== 1'b0 || bus.Prdata !== 32'd0) begin
      errors++;
      $display("[TB] FAIL idle_outputs: got ready=%b err=%b rdata=%h, want 0/0/0",
               bus.Pready, bus.Pslverr, bus.Prdata);
    end
    foreach (addrs[i]) begin
      apb_xfer(1'b0, addrs[i], 32'd0, rd, se, w, ok);
      checks++;
      if (!ok || w !== int'(model_wait)) begin
        errors++;
        $display("[TB] FAIL reset_read_latency addr=%h: got ok=%0d waits=%0d, want waits=%0d",
                 addrs[i], ok, w, model_wait);
      end
      checks++;
      if (rd !== model_read(1'b0, addrs[i]) || se !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_read_data addr=%h: got %h err=%b, want %h err=0",
                 addrs[i], rd, se, model_read(1'b0, addrs[i]));
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    logic        se;
    int          w;
    bit          ok;
    logic [31:0] exp_rd;
    bit          wr_tab [3];
    logic [ADDR_W-1:0] a_tab [3];
    logic [31:0] d_tab [3];
    wr_tab[0] = 1'b1; a_tab[0] = 12'h038; d_tab[0] = 32'h0000_0000;
    wr_tab[1] = 1'b1; a_tab[1] = 12'h008; d_tab[1] = 32'hDEAD_BEEF;
    wr_tab[2] = 1'b0; a_tab[2] = 12'h008; d_tab[2] = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      exp_rd = model_read(wr_tab[i], a_tab[i]);
      apb_xfer(wr_tab[i], a_tab[i], d_tab[i], rd, se, w, ok);
      checks++;
      if (!ok || w !== int'(model_wait)) begin
        errors++;
        $display("[TB] FAIL basic_latency #%0d: got ok=%0d waits=%0d, want waits=%0d",
                 i, ok, w, model_wait);
      end
      checks++;
      if (se !== 1'b0 || (!wr_tab[i] && rd !== exp_rd)) begin
        errors++;
        $display("[TB] FAIL basic_data #%0d: got %h err=%b, want %h err=0", i, rd, se, exp_rd);
      end
      model_write(wr_tab[i], a_tab[i], d_tab[i]);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    logic        se;
    int          w;
    bit          ok;
    logic [3:0]  cfg_tab [3];
    cfg_tab[0] = 4'd3;
    cfg_tab[1] = 4'd15;
    cfg_tab[2] = 4'd0;
    foreach (cfg_tab[i]) begin
      apb_xfer(1'b1, 12'h038, {28'hFFFF_FFF, cfg_tab[i]}, rd, se, w, ok);
      checks++;
      if (!ok || w !== int'(model_wait)) begin
        errors++;
        $display("[TB] FAIL cfg_write_latency cfg=%0d: got ok=%0d waits=%0d, want waits=%0d",
                 cfg_tab[i], ok, w, model_wait);
      end
      model_write(1'b1, 12'h038, {28'hFFFF_FFF, cfg_tab[i]});
      apb_xfer(1'b0, 12'h038, 32'd0, rd, se, w, ok);
      checks++;
      if (!ok || w !== int'(cfg_tab[i])) begin
        errors++;
        $display("[TB] FAIL wait_latency cfg=%0d: got ok=%0d waits=%0d, want %0d",
                 cfg_tab[i], ok, w, cfg_tab[i]);
      end
      checks++;
      if (rd !== {28'd0, cfg_tab[i]} || se !== 1'b0) begin
        errors++;
        $display("[TB] FAIL wait_cfg_read: got %h err=%b, want %h err=0",
                 rd, se, {28'd0, cfg_tab[i]});
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        se;
    int          w;
    bit          ok;
    bit          wr_tab [4];
    logic [ADDR_W-1:0] a_tab [4];
    wr_tab[0] = 1'b1; a_tab[0] = 12'h03C;
    wr_tab[1] = 1'b1; a_tab[1] = 12'h006;
    wr_tab[2] = 1'b0; a_tab[2] = 12'h040;
    wr_tab[3] = 1'b0; a_tab[3] = 12'h03C;
    for (int i = 0; i < 4; i++) begin
      apb_xfer(wr_tab[i], a_tab[i], 32'hFFFF_FFFF, rd, se, w, ok);
      checks++;
      if (!ok || se !== model_err(wr_tab[i], a_tab[i]) || rd !== model_read(wr_tab[i], a_tab[i])) begin
        errors++;
        $display("[TB] FAIL error_resp addr=%h wr=%0d: got ok=%0d err=%b rdata=%h, want err=%0d rdata=%h",
                 a_tab[i], wr_tab[i], ok, se, rd, model_err(wr_tab[i], a_tab[i]),
                 model_read(wr_tab[i], a_tab[i]));
      end
      model_write(wr_tab[i], a_tab[i], 32'hFFFF_FFFF);
    end
    apb_xfer(1'b0, 12'h004, 32'd0, rd, se, w, ok);
    checks++;
    if (rd !== model_regs[1] || se !== 1'b0) begin
      errors++;
      $display("[TB] FAIL error_no_side_effect: got %h err=%b, want %h", rd, se, model_regs[1]);
    end
  endtask

  task automatic test_protocol();
    logic [31:0] rd;
    logic        se;
    int          w;
    bit          ok;
    bus.Psel    = 1'b1;
    bus.Penable = 1'b1;
    bus.Pwrite  = 1'b1;
    bus.Paddr   = 12'h014;
    bus.Pwdata  = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.Pready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL enable_without_setup cycle %0d: got Pready=%b, want 0", i, bus.Pready);
      end
      @(posedge Pclk); #1;
    end
    idle_bus();
    @(posedge Pclk); #1;
    apb_xfer(1'b1, 12'h038, 32'd4, rd, se, w, ok);
    model_write(1'b1, 12'h038, 32'd4);
    apb_xfer(1'b1, 12'h014, 32'h5555_AAAA, rd, se, w, ok);
    model_write(1'b1, 12'h014, 32'h5555_AAAA);
    bus.Psel    = 1'b1;
    bus.Penable = 1'b0;
    bus.Pwrite  = 1'b1;
    bus.Paddr   = 12'h014;
    bus.Pwdata  = 32'hCAFE_F00D;
    @(posedge Pclk); #1;
    bus.Penable = 1'b1;
    @(posedge Pclk); @(posedge Pclk); #1;
    idle_bus();
    #1;
    checks++;
    if (bus.Pready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_ready: got Pready=%b, want 0", bus.Pready);
    end
    @(posedge Pclk); #1;
    apb_xfer(1'b0, 12'h014, 32'd0, rd, se, w, ok);
    checks++;
    if (!ok || rd !== model_regs[5] || w !== int'(model_wait)) begin
      errors++;
      $display("[TB] FAIL abort_no_write: got ok=%0d rdata=%h waits=%0d, want %h waits=%0d",
               ok, rd, w, model_regs[5], model_wait);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic        se;
    int          w;
    bit          ok;
    logic [31:0] exp_rd;
    bit          wr_tab [3];
    logic [ADDR_W-1:0] a_tab [3];
    logic [31:0] d_tab [3];
    wr_tab[0] = 1'b1; a_tab[0] = 12'h020; d_tab[0] = $urandom;
    wr_tab[1] = 1'b1; a_tab[1] = 12'h024; d_tab[1] = $urandom;
    wr_tab[2] = 1'b0; a_tab[2] = 12'h020; d_tab[2] = 32'd0;
    for (int i = 0; i < 3; i++) begin
      exp_rd = model_read(wr_tab[i], a_tab[i]);
      apb_xfer(wr_tab[i], a_tab[i], d_tab[i], rd, se, w, ok);
      checks++;
      if (!ok || w !== int'(model_wait) || se !== 1'b0 || (!wr_tab[i] && rd !== exp_rd)) begin
        errors++;
        $display("[TB] FAIL back_to_back #%0d: got ok=%0d waits=%0d err=%b rdata=%h, want waits=%0d rdata=%h",
                 i, ok, w, se, rd, model_wait, exp_rd);
      end
      model_write(wr_tab[i], a_tab[i], d_tab[i]);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic        se;
    int          w;
    bit          ok;
    bit          wr;
    logic [ADDR_W-1:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_w;
    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom);
      d  = $urandom;
      if ($urandom_range(0, 5) == 0) a = ADDR_W'($urandom);
      else a = ADDR_W'($urandom_range(0, 15) * 4);
      exp_rd  = model_read(wr, a);
      exp_err = model_err(wr, a);
      exp_w   = int'(model_wait);
      apb_xfer(wr, a, d, rd, se, w, ok);
      checks++;
      if (!ok || w !== exp_w || se !== exp_err || ((!wr || exp_err) && rd !== exp_rd)) begin
        errors++;
        $display("[TB] FAIL random #%0d wr=%0d addr=%h: got ok=%0d waits=%0d err=%b rdata=%h, want waits=%0d err=%0d rdata=%h",
                 i, wr, a, ok, w, se, rd, exp_w, exp_err, exp_rd);
      end
      model_write(wr, a, d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        se;
    int          w;
    bit          ok;
    apb_xfer(1'b1, 12'h038, 32'd4, rd, se, w, ok);
    model_write(1'b1, 12'h038, 32'd4);
    bus.Psel    = 1'b1;
    bus.Penable = 1'b0;
    bus.Pwrite  = 1'b1;
    bus.Paddr   = 12'h00C;
    bus.Pwdata  = 32'h7777_1234;
    @(posedge Pclk); #1;
    bus.Penable = 1'b1;
    @(posedge Pclk); #1;
    Preset = 1'b1;
    #1;
    checks++;
    if (bus.Pready !== 1'b0 || bus.Pslverr !== 1'b0 || bus.Prdata !== 32'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: got ready=%b err=%b rdata=%h, want 0/0/0",
               bus.Pready, bus.Pslverr, bus.Prdata);
    end
    model_reset();
    @(posedge Pclk); #1;
    checks++;
    if (bus.Pready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_hold: got Pready=%b with Psel/Penable high, want 0", bus.Pready);
    end
    idle_bus();
    Preset = 1'b0;
    @(posedge Pclk); #1;
    apb_xfer(1'b0, 12'h00C, 32'd0, rd, se, w, ok);
    checks++;
    if (!ok || rd !== 32'd0 || w !== int'(WAIT_RST)) begin
      errors++;
      $display("[TB] FAIL mid_reset_discard: got ok=%0d rdata=%h waits=%0d, want 0 waits=%0d",
               ok, rd, w, WAIT_RST);
    end
    apb_xfer(1'b0, 12'h038, 32'd0, rd, se, w, ok);
    checks++;
    if (rd !== {28'd0, WAIT_RST}) begin
      errors++;
      $display("[TB] FAIL mid_reset_wait_cfg: got %h, want %h", rd, {28'd0, WAIT_RST});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_errors();
    test_protocol();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
